data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Load/store sequencer between the EXE/MEM pipeline boundary and the SRAM-like data bus (req/addr_ok/data_ok).
//  Accepts one memory op at a time and builds byte strobes and replicated store data.
//  Tracks the bus transaction, extends load data to 32 bits and holds the result until MEM consumes it.
//  MEM uses resp_valid as its ready_go. cancel (exception/flush) drops or drains an in-flight access.
// PARAMETERS
//  ALIGN_CHECK  1  1: misaligned half/word ops skip the bus and return resp_ale=1; 0: address low bits ignored
// PORTS
//  clk               in   1   clock; all state updates on posedge
//  reset             in   1   synchronous, active-high
//  req_valid         in   1   EXE presents a memory op
//  req_ready         out  1   op accepted this cycle when req_valid&&req_ready
//  req_wr            in   1   1=store, 0=load
//  req_size          in   2   0=byte, 1=half, 2=word, 3=treated as word
//  req_unsigned      in   1   load zero-extends (1) or sign-extends (0)
//  req_addr          in   32  byte address
//  req_wdata         in   32  store data, low-aligned
//  resp_valid        out  1   result ready (MEM ready_go)
//  resp_ready        in   1   MEM consumes result (wb_allow_in path)
//  resp_rdata        out  32  extended load data; 0 for stores and ALE
//  resp_ale          out  1   address-alignment error for this op
//  cancel            in   1   flush: abandon current op, no resp produced
//  data_sram_req     out  1   bus request
//  data_sram_wr      out  1   bus write
//  data_sram_size    out  2   0/1/2 = 1/2/4 bytes
//  data_sram_wstrb   out  4   byte lane enables (stores only; 0 for loads)
//  data_sram_addr    out  32  latched req_addr
//  data_sram_wdata   out  32  replicated store data
//  data_sram_addr_ok in   1   bus accepted request
//  data_sram_data_ok in   1   bus completed (read data valid / write done)
//  data_sram_rdata   in   32  raw read word
// BEHAVIOUR
//  States: IDLE, REQ, WAIT, DONE, DRAIN. Reset -> IDLE; data_sram_req=0, resp_valid=0, resp_ale=0, resp_rdata=0.
//  req_ready = IDLE || (DONE && resp_ready); forced 0 when cancel=1.
//  Accept: latch wr/size/unsigned/addr/wdata. Misaligned (ALIGN_CHECK) -> DONE with ale=1, no bus access. Otherwise -> REQ.
//  REQ: data_sram_req=1, all bus fields stable from latch. addr_ok -> WAIT. No addr_ok -> stay in REQ.
//  WAIT: data_sram_req=0. data_ok -> DONE; capture extended rdata on loads, 0 on stores.
//  data_ok is sampled only in WAIT/DRAIN. The bus returns data_ok >=1 cycle after addr_ok and keeps at most one outstanding.
//  DONE: resp_valid=1, data held stable. resp_ready -> IDLE, or -> REQ/DONE if a new op is accepted the same cycle.
//  Min latency: accept at edge T, req in T+1, addr_ok T+1, data_ok T+2, resp_valid in T+3.
//  cancel (priority over all else):
//   - REQ without addr_ok -> IDLE.
//   - REQ with addr_ok, or WAIT without data_ok -> DRAIN.
//   - WAIT with data_ok -> IDLE.
//   - DONE -> IDLE.
//   - IDLE/DRAIN: no effect.
//  A cancelled store that already got addr_ok still writes memory.
//  DRAIN: req=0, req_ready=0. data_ok discards data -> IDLE. Never emits resp_valid.
//  wstrb: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
//  wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word as is.
//  Load extract: byte rdata[8*addr[1:0]+:8]; half rdata[16*addr[1]+:16]; ext per req_unsigned to 32 bits.
//  Reset in any state, including mid-transaction, -> IDLE next edge; outstanding data_ok afterwards ignored.
// TESTING
//  lb addr=0x1003, rdata=0x80FF_1234, addr_ok T+1, data_ok T+2 -> resp_rdata=0xFFFF_FF80 valid at T+3.
//  sh addr=0x2002 wdata=0x0000_BEEF -> wstrb=4'b1100, wdata=0xBEEF_BEEF, size=1; resp_rdata=0.
//  lw addr=0x3001, ALIGN_CHECK=1 -> no data_sram_req ever, resp_valid next cycle with resp_ale=1.
//  lhu addr=0x4002; addr_ok stalls 3 cycles -> req/addr held stable, rdata=0xABCD_0000 -> resp_rdata=0x0000_ABCD.
//  cancel in the addr_ok cycle, data_ok 2 cycles later -> DRAIN, req_ready=0, no resp_valid, then IDLE.
//  resp_ready=0 for 4 cycles in DONE -> resp held; resp_ready with req_valid -> back-to-back accept, req next cycle.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Load/store sequencer between the EXE/MEM boundary and an SRAM-like data bus.
// One op in flight; builds strobes/replicated store data and holds the extended load result for MEM.
module data_mem_ctrl #(
    parameter int ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_ale,
    input  logic        cancel,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ale_q, ale_d;
    logic        req_q, req_d;
    logic        resp_valid_q, resp_valid_d;

    logic [1:0]  req_size_norm;
    logic        req_misaligned;
    logic [3:0]  store_wstrb;
    logic [31:0] store_wdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic        accept;

    assign req_ready = ((state_q == S_IDLE) || ((state_q == S_DONE) && resp_ready)) && !cancel;
    assign accept    = req_valid && req_ready;

    // Size 3 behaves as a word everywhere, including on the bus size field.
    always_comb begin
        req_size_norm  = (req_size == 2'd3) ? 2'd2 : req_size;
        req_misaligned = 1'b0;
        if (ALIGN_CHECK != 0) begin
            case (req_size_norm)
                2'd1:    req_misaligned = req_addr[0];
                2'd2:    req_misaligned = (req_addr[1:0] != 2'b00);
                default: req_misaligned = 1'b0;
            endcase
        end
        case (req_size_norm)
            2'd0: begin
                store_wstrb = 4'b0001 << req_addr[1:0];
                store_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                store_wstrb = 4'b0011 << {req_addr[1], 1'b0};
                store_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                store_wstrb = 4'b1111;
                store_wdata = req_wdata;
            end
        endcase
        if (!req_wr) begin
            store_wstrb = 4'b0000;
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    load_byte = data_sram_rdata[7:0];
            2'd1:    load_byte = data_sram_rdata[15:8];
            2'd2:    load_byte = data_sram_rdata[23:16];
            default: load_byte = data_sram_rdata[31:24];
        endcase
        load_half = addr_q[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
        case (size_q)
            2'd0:    load_ext = {{24{~unsigned_q & load_byte[7]}}, load_byte};
            2'd1:    load_ext = {{16{~unsigned_q & load_half[15]}}, load_half};
            default: load_ext = data_sram_rdata;
        endcase
    end

    // cancel outranks every bus event; an accepted op overrides the state decision below.
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        ale_d      = ale_q;
        case (state_q)
            S_IDLE: ;
            S_REQ: begin
                if (cancel) begin
                    state_d = data_sram_addr_ok ? S_DRAIN : S_IDLE;
                end else if (data_sram_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_sram_data_ok) begin
                    if (cancel) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        rdata_d = wr_q ? 32'h0 : load_ext;
                    end
                end else if (cancel) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (cancel || resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (data_sram_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            wr_d       = req_wr;
            size_d     = req_size_norm;
            unsigned_d = req_unsigned;
            addr_d     = req_addr;
            wdata_d    = store_wdata;
            wstrb_d    = store_wstrb;
            rdata_d    = 32'h0;
            ale_d      = req_misaligned;
            state_d    = req_misaligned ? S_DONE : S_REQ;
        end
        req_d        = (state_d == S_REQ);
        resp_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            unsigned_q   <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            rdata_q      <= 32'h0;
            ale_q        <= 1'b0;
            req_q        <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdata_q      <= rdata_d;
            ale_q        <= ale_d;
            req_q        <= req_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign data_sram_req   = req_q;
    assign data_sram_wr    = wr_q;
    assign data_sram_size  = size_q;
    assign data_sram_wstrb = wstrb_q;
    assign data_sram_addr  = addr_q;
    assign data_sram_wdata = wdata_q;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = rdata_q;
    assign resp_ale        = ale_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: transaction-level model checked every cycle, plus directed literal checks.
module tb_data_mem_ctrl;

    localparam int ALIGN_CHECK = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_ale;
    logic        cancel = 1'b0;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok = 1'b0;
    logic        data_sram_data_ok = 1'b0;
    logic [31:0] data_sram_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ALIGN_CHECK(ALIGN_CHECK)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_wr            (req_wr),
        .req_size          (req_size),
        .req_unsigned      (req_unsigned),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_rdata        (resp_rdata),
        .resp_ale          (resp_ale),
        .cancel            (cancel),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [1:0] norm_size(input logic [1:0] s);
        return (s == 2'd3) ? 2'd2 : s;
    endfunction

    function automatic bit misaligned(input logic [1:0] s, input logic [31:0] a);
        return (ALIGN_CHECK != 0) && ((int'(a[1:0]) % nbytes(s)) != 0);
    endfunction

    function automatic int lane_base(input logic [1:0] s, input logic [31:0] a);
        int nb = nbytes(s);
        return (int'(a[1:0]) / nb) * nb;
    endfunction

    function automatic logic [3:0] exp_wstrb(input logic wr, input logic [1:0] s, input logic [31:0] a);
        logic [3:0] r = 4'h0;
        int base = lane_base(s, a);
        int nb = nbytes(s);
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= base && i < base + nb) r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] s, input logic [31:0] wd);
        logic [31:0] r = 32'h0;
        int nb = nbytes(s);
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic uns, input logic [1:0] s, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        logic [31:0] mask;
        int nb = nbytes(s);
        v = rd >> (8 * lane_base(s, a));
        if (nb == 4) return v;
        mask = (32'h1 << (8 * nb)) - 32'h1;
        v = v & mask;
        if (!uns && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // Transaction model: one op record with progress flags, plus a drain flag for a cancelled bus access.
    logic        m_have = 1'b0, m_ale = 1'b0, m_addr_done = 1'b0, m_data_done = 1'b0, m_drain = 1'b0;
    logic        m_wr = 1'b0, m_uns = 1'b0;
    logic [1:0]  m_size = 2'd0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_rdata = 32'h0;

    function automatic bit mdl_req();
        return m_have && !m_ale && !m_addr_done;
    endfunction

    function automatic bit mdl_wait();
        return m_have && m_addr_done && !m_data_done;
    endfunction

    function automatic bit mdl_resp();
        return m_have && (m_ale || m_data_done);
    endfunction

    function automatic bit mdl_ready();
        return ((!m_have && !m_drain) || (mdl_resp() && resp_ready)) && !cancel;
    endfunction

    always @(posedge clk) begin : model_update
        bit rdy;
        if (reset) begin
            m_have = 1'b0;
            m_drain = 1'b0;
            m_addr_done = 1'b0;
            m_data_done = 1'b0;
            m_ale = 1'b0;
        end else begin
            rdy = mdl_ready();
            if (m_drain) begin
                if (data_sram_data_ok) m_drain = 1'b0;
            end else if (mdl_req()) begin
                if (cancel) begin
                    m_have = 1'b0;
                    m_drain = data_sram_addr_ok;
                end else if (data_sram_addr_ok) begin
                    m_addr_done = 1'b1;
                end
            end else if (mdl_wait()) begin
                if (cancel) begin
                    m_have = 1'b0;
                    m_drain = !data_sram_data_ok;
                end else if (data_sram_data_ok) begin
                    m_data_done = 1'b1;
                    m_rdata = m_wr ? 32'h0 : exp_load(m_uns, m_size, m_addr, data_sram_rdata);
                end
            end else if (mdl_resp()) begin
                if (cancel || resp_ready) m_have = 1'b0;
            end
            if (rdy && req_valid) begin
                m_have = 1'b1;
                m_wr = req_wr;
                m_size = norm_size(req_size);
                m_uns = req_unsigned;
                m_addr = req_addr;
                m_wdata = req_wdata;
                m_ale = misaligned(req_size, req_addr);
                m_addr_done = 1'b0;
                m_data_done = 1'b0;
                m_rdata = 32'h0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("req_ready", 32'(req_ready), 32'(mdl_ready()));
            checkOutput("sram_req", 32'(data_sram_req), 32'(mdl_req()));
            if (mdl_req()) begin
                checkOutput("sram_addr", data_sram_addr, m_addr);
                checkOutput("sram_wr", 32'(data_sram_wr), 32'(m_wr));
                checkOutput("sram_size", 32'(data_sram_size), 32'(m_size));
                checkOutput("sram_wstrb", 32'(data_sram_wstrb), 32'(exp_wstrb(m_wr, m_size, m_addr)));
                if (m_wr) checkOutput("sram_wdata", data_sram_wdata, exp_wdata(m_size, m_wdata));
            end
            checkOutput("resp_valid", 32'(resp_valid), 32'(mdl_resp()));
            if (mdl_resp()) begin
                checkOutput("resp_rdata", resp_rdata, m_rdata);
                checkOutput("resp_ale", 32'(resp_ale), 32'(m_ale));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic [1:0] s, input logic uns,
                                 input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        req_wr = wr;
        req_size = s;
        req_unsigned = uns;
        req_addr = a;
        req_wdata = wd;
    endtask

    // Full op from an idle controller: stall cycles before addr_ok, dly cycles from addr_ok to data_ok.
    task automatic runOp(input logic wr, input logic [1:0] s, input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int stall, input int dly);
        applyStimulus(wr, s, uns, a, wd);
        tick();
        req_valid = 1'b0;
        if (!misaligned(s, a)) begin
            repeat (stall) tick();
            data_sram_addr_ok = 1'b1;
            tick();
            data_sram_addr_ok = 1'b0;
            repeat (dly - 1) tick();
            data_sram_data_ok = 1'b1;
            data_sram_rdata = rd;
            tick();
            data_sram_data_ok = 1'b0;
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_sram_req", 32'(data_sram_req), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
        checkOutput("rst_resp_ale", 32'(resp_ale), 32'd0);

        // lb 0x1003 at minimum latency
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0);
        tick();
        req_valid = 1'b0;
        checkOutput("lb_req", 32'(data_sram_req), 32'd1);
        checkOutput("lb_wstrb", 32'(data_sram_wstrb), 32'h0);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80FF_1234;
        tick();
        data_sram_data_ok = 1'b0;
        checkOutput("lb_valid", 32'(resp_valid), 32'd1);
        checkOutput("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // sh 0x2002
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
        tick();
        req_valid = 1'b0;
        checkOutput("sh_wstrb", 32'(data_sram_wstrb), 32'hC);
        checkOutput("sh_wdata", data_sram_wdata, 32'hBEEF_BEEF);
        checkOutput("sh_size", 32'(data_sram_size), 32'd1);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        tick();
        data_sram_data_ok = 1'b1;
        tick();
        data_sram_data_ok = 1'b0;
        checkOutput("sh_rdata", resp_rdata, 32'h0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // misaligned lw 0x3001
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0);
        tick();
        req_valid = 1'b0;
        checkOutput("ale_req", 32'(data_sram_req), 32'd0);
        checkOutput("ale_valid", 32'(resp_valid), 32'd1);
        checkOutput("ale_flag", 32'(resp_ale), 32'd1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // lhu 0x4002 with addr_ok stalled 3 cycles
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h0000_4002, 32'h0);
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        checkOutput("lhu_addr_held", data_sram_addr, 32'h0000_4002);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hABCD_0000;
        tick();
        data_sram_data_ok = 1'b0;
        checkOutput("lhu_rdata", resp_rdata, 32'h0000_ABCD);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // cancel in the addr_ok cycle, data_ok two cycles later
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0);
        tick();
        req_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        cancel = 1'b1;
        #1;
        checkOutput("cancel_ready", 32'(req_ready), 32'd0);
        tick();
        data_sram_addr_ok = 1'b0;
        cancel = 1'b0;
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h0000_5100, 32'h0);
        #1;
        checkOutput("drain_ready", 32'(req_ready), 32'd0);
        tick();
        req_valid = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h1111_2222;
        tick();
        data_sram_data_ok = 1'b0;
        checkOutput("drain_no_resp", 32'(resp_valid), 32'd0);
        checkOutput("drain_to_idle", 32'(req_ready), 32'd1);

        // resp held for 4 cycles, then back-to-back accept
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_6004, 32'h0);
        tick();
        req_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h1234_5678;
        tick();
        data_sram_data_ok = 1'b0;
        repeat (4) tick();
        checkOutput("hold_rdata", resp_rdata, 32'h1234_5678);
        resp_ready = 1'b1;
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h0000_6007, 32'h0);
        #1;
        checkOutput("b2b_ready", 32'(req_ready), 32'd1);
        tick();
        resp_ready = 1'b0;
        req_valid = 1'b0;
        checkOutput("b2b_req", 32'(data_sram_req), 32'd1);
        checkOutput("b2b_addr", data_sram_addr, 32'h0000_6007);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hA500_0000;
        tick();
        data_sram_data_ok = 1'b0;
        checkOutput("b2b_rdata", resp_rdata, 32'h0000_00A5);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // cancel in REQ before addr_ok
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h0000_7000, 32'h0);
        tick();
        req_valid = 1'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checkOutput("cxl_req_gone", 32'(data_sram_req), 32'd0);

        // cancel in WAIT without data_ok, then drain
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_7004, 32'h0);
        tick();
        req_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        data_sram_data_ok = 1'b1;
        tick();
        data_sram_data_ok = 1'b0;

        // cancel in WAIT together with data_ok
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_7008, 32'h0);
        tick();
        req_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        cancel = 1'b1;
        data_sram_data_ok = 1'b1;
        tick();
        cancel = 1'b0;
        data_sram_data_ok = 1'b0;
        checkOutput("cxl_wait_ok", 32'(resp_valid), 32'd0);

        // cancel in DONE blocks a same-cycle accept
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_7010, 32'h0);
        tick();
        req_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        tick();
        data_sram_data_ok = 1'b0;
        cancel = 1'b1;
        resp_ready = 1'b1;
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h0000_7020, 32'h0);
        tick();
        cancel = 1'b0;
        resp_ready = 1'b0;
        req_valid = 1'b0;
        checkOutput("cxl_done_req", 32'(data_sram_req), 32'd0);

        // cancel while idle blocks accept
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h0000_7030, 32'h5555_AAAA);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        req_valid = 1'b0;
        checkOutput("cxl_idle_req", 32'(data_sram_req), 32'd0);

        // reset mid-transaction; the late data_ok must be ignored
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'h0);
        tick();
        req_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        data_sram_data_ok = 1'b1;
        tick();
        data_sram_data_ok = 1'b0;
        checkOutput("rst_mid_resp", 32'(resp_valid), 32'd0);
        checkOutput("rst_mid_ready", 32'(req_ready), 32'd1);

        // assorted sizes, offsets and bus timings
        runOp(1'b1, 2'd0, 1'b0, 32'h0000_9001, 32'h1234_5678, 32'h0, 0, 1);
        runOp(1'b0, 2'd1, 1'b0, 32'h0000_9002, 32'h0, 32'h8001_7FFF, 1, 2);
        runOp(1'b0, 2'd1, 1'b0, 32'h0000_9000, 32'h0, 32'h8001_7FFF, 0, 1);
        runOp(1'b0, 2'd0, 1'b1, 32'h0000_9002, 32'h0, 32'h00C3_0000, 2, 1);
        runOp(1'b1, 2'd3, 1'b0, 32'h0000_9004, 32'hDEAD_BEEF, 32'h0, 0, 3);
        runOp(1'b0, 2'd3, 1'b0, 32'h0000_9008, 32'h0, 32'hCAFE_F00D, 1, 1);
        runOp(1'b1, 2'd1, 1'b0, 32'h0000_9001, 32'h0000_1234, 32'h0, 0, 1);
        runOp(1'b0, 2'd0, 1'b0, 32'h0000_9000, 32'h0, 32'h0000_007F, 0, 1);

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
